// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default parameters, pointer
// width derivation and the per-cycle access decode type.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_MEM_DEPTH     = 8;
    localparam int DEF_AFULL_THRESH  = 6;
    localparam int DEF_AEMPTY_THRESH = 2;
    localparam int DEF_FWFT          = 1;

    // Accepted-access combination for one cycle, encoded as {read, write}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Storage address width; the pointers carry one extra wrap bit on top.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int ptr_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int ADDR_W     = addr_width(MEM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO: pointer control, occupancy flags, sticky error flags and
// a build-time choice between fall-through and registered read data.
module sync_fifo_top
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    parameter int FWFT          = DEF_FWFT
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                WR_EN,
    input  logic [DATA_WIDTH-1:0]               WR_DATA,
    input  logic                                RD_EN,
    output logic [DATA_WIDTH-1:0]               RD_DATA,
    output logic                                RD_VALID,
    output logic                                FULL,
    output logic                                EMPTY,
    output logic                                ALMOST_FULL,
    output logic                                ALMOST_EMPTY,
    output logic [$clog2(MEM_DEPTH):0]          COUNT,
    output logic                                OVERFLOW,
    output logic                                UNDERFLOW,
    input  logic                                CLR_ERR
);

    localparam int ADDR_W = addr_width(MEM_DEPTH);
    localparam int PTR_W  = ptr_width(MEM_DEPTH);
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AEMPTY_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] head_data;
    fifo_op_e              op;

    // Flags look only at registered pointers, so a same-cycle read never
    // frees space for a write and a same-cycle write never feeds a read.
    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    assign wr_accept = WR_EN && !full;
    assign rd_accept = RD_EN && !empty;
    assign op        = fifo_op_e'({rd_accept, wr_accept});

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        case (op)
            OP_WRITE: wptr_d = wptr_q + PTR_ONE;
            OP_READ:  rptr_d = rptr_q + PTR_ONE;
            OP_BOTH: begin
                wptr_d = wptr_q + PTR_ONE;
                rptr_d = rptr_q + PTR_ONE;
            end
            default: ;
        endcase
    end

    // Setting beats clearing when both happen in the same cycle.
    always_comb begin
        overflow_d  = (overflow_q  && !CLR_ERR) || (WR_EN && full);
        underflow_d = (underflow_q && !CLR_ERR) || (RD_EN && empty);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (wr_accept),
        .wr_addr (wptr_q[ADDR_W-1:0]),
        .wr_data (WR_DATA),
        .rd_addr (rptr_q[ADDR_W-1:0]),
        .rd_data (head_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign RD_DATA  = head_data;
            assign RD_VALID = !empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            // Data holds its last value between accepted reads.
            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_accept;
                if (rd_accept) begin
                    rd_data_d = head_data;
                end
            end

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign RD_DATA  = rd_data_q;
            assign RD_VALID = rd_valid_q;
        end
    endgenerate

    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count >= AF_LEVEL);
    assign ALMOST_EMPTY = (count <= AE_LEVEL);
    assign COUNT        = count;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_top.sv
// Drives a fall-through and a registered-read FIFO with identical stimulus and
// checks both against a queue-based reference model after every clock.
module tb_sync_fifo_top;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       RD_EN;
    logic       CLR_ERR;

    logic [7:0] f_rd_data, r_rd_data;
    logic       f_rd_valid, r_rd_valid;
    logic       f_full, r_full, f_empty, r_empty;
    logic       f_af, r_af, f_ae, r_ae;
    logic [3:0] f_count, r_count;
    logic       f_ovf, r_ovf, f_udf, r_udf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_udf;
    bit         m_rv;
    logic [7:0] m_rd;

    always #5 CLK = ~CLK;

    sync_fifo_top #(
        .DATA_WIDTH(8), .MEM_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)
    ) u_fwft (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
        .RD_DATA(f_rd_data), .RD_VALID(f_rd_valid), .FULL(f_full), .EMPTY(f_empty),
        .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae), .COUNT(f_count),
        .OVERFLOW(f_ovf), .UNDERFLOW(f_udf), .CLR_ERR(CLR_ERR)
    );

    sync_fifo_top #(
        .DATA_WIDTH(8), .MEM_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)
    ) u_reg (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
        .RD_DATA(r_rd_data), .RD_VALID(r_rd_valid), .FULL(r_full), .EMPTY(r_empty),
        .ALMOST_FULL(r_af), .ALMOST_EMPTY(r_ae), .COUNT(r_count),
        .OVERFLOW(r_ovf), .UNDERFLOW(r_udf), .CLR_ERR(CLR_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
        m_rv  = 0;
        m_rd  = 8'h00;
    endtask

    task automatic check_state(input string step);
        int sz;
        sz = mq.size();
        chk({step, " f_count"}, 32'(f_count), 32'(sz));
        chk({step, " r_count"}, 32'(r_count), 32'(sz));
        chk({step, " f_empty"}, 32'(f_empty), 32'(sz == 0));
        chk({step, " r_empty"}, 32'(r_empty), 32'(sz == 0));
        chk({step, " f_full"},  32'(f_full),  32'(sz == 8));
        chk({step, " r_full"},  32'(r_full),  32'(sz == 8));
        chk({step, " f_af"},    32'(f_af),    32'(sz >= 6));
        chk({step, " r_af"},    32'(r_af),    32'(sz >= 6));
        chk({step, " f_ae"},    32'(f_ae),    32'(sz <= 2));
        chk({step, " r_ae"},    32'(r_ae),    32'(sz <= 2));
        chk({step, " f_ovf"},   32'(f_ovf),   32'(m_ovf));
        chk({step, " r_ovf"},   32'(r_ovf),   32'(m_ovf));
        chk({step, " f_udf"},   32'(f_udf),   32'(m_udf));
        chk({step, " r_udf"},   32'(r_udf),   32'(m_udf));
        chk({step, " f_rd_valid"}, 32'(f_rd_valid), 32'(sz != 0));
        if (sz != 0) chk({step, " f_rd_data"}, 32'(f_rd_data), 32'(mq[0]));
        chk({step, " r_rd_valid"}, 32'(r_rd_valid), 32'(m_rv));
        chk({step, " r_rd_data"},  32'(r_rd_data),  32'(m_rd));
    endtask

    // One clock with the given requests; model follows the FIFO rules directly.
    task automatic cycle(input string step, input bit wr, input logic [7:0] wd,
                         input bit rd, input bit clr);
        bit was_full, was_empty, wacc, racc;
        logic [7:0] head;
        WR_EN   = wr;
        WR_DATA = wd;
        RD_EN   = rd;
        CLR_ERR = clr;
        @(posedge CLK);
        was_full  = (mq.size() == 8);
        was_empty = (mq.size() == 0);
        wacc = wr && !was_full;
        racc = rd && !was_empty;
        head = was_empty ? 8'h00 : mq[0];
        if (racc) void'(mq.pop_front());
        if (wacc) mq.push_back(wd);
        m_ovf = (m_ovf && !clr) || (wr && was_full);
        m_udf = (m_udf && !clr) || (rd && was_empty);
        m_rv  = racc;
        if (racc) m_rd = head;
        #1;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        CLR_ERR = 1'b0;
        $display("[%0t] %s wr=%0b wd=%02h rd=%0b clr=%0b -> count=%0d f_head=%02h r_data=%02h r_valid=%0b",
                 $time, step, wr, wd, rd, clr, f_count, f_rd_data, r_rd_data, r_rd_valid);
        check_state(step);
    endtask

    initial begin
        RST = 1'b0; WR_EN = 1'b0; WR_DATA = 8'h00; RD_EN = 1'b0; CLR_ERR = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        check_state("reset");

        // 1: asynchronous reset mid-traffic
        for (int i = 0; i < 5; i++) cycle("t1_wr", 1, 8'($urandom), 0, 0);
        chk("t1_count5", 32'(f_count), 32'd5);
        #3 RST = 1'b0;
        #1;
        model_reset();
        check_state("t1_async_rst");
        chk("t1_empty_now", 32'(f_empty), 32'd1);
        @(posedge CLK);
        #1 RST = 1'b1;
        check_state("t1_release");

        // 2: fill then overflow
        for (int i = 1; i <= 8; i++) cycle("t2_fill", 1, 8'(i * 8'h11), 0, 0);
        chk("t2_full", 32'(f_full), 32'd1);
        cycle("t2_over", 1, 8'h99, 0, 0);
        chk("t2_ovf", 32'(r_ovf), 32'd1);
        chk("t2_count", 32'(r_count), 32'd8);

        // 3: drain then underflow
        for (int i = 1; i <= 8; i++) begin
            cycle("t3_drain", 0, 8'h00, 1, 0);
            chk("t3_order", 32'(r_rd_data), 32'(i * 8'h11));
        end
        cycle("t3_under", 0, 8'h00, 1, 0);
        chk("t3_udf", 32'(f_udf), 32'd1);
        cycle("t3_clr", 0, 8'h00, 0, 1);

        // 4: pointer wrap
        for (int i = 0; i < 5; i++) cycle("t4_wr5", 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 5; i++) cycle("t4_rd5", 0, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) cycle("t4_wr8", 1, 8'(8'hA0 + i), 0, 0);
        chk("t4_full", 32'(f_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_head", 32'(f_rd_data), 32'(8'hA0 + i));
            cycle("t4_rd8", 0, 8'h00, 1, 0);
        end

        // 5: simultaneous access at middle, empty and full
        for (int i = 0; i < 3; i++) cycle("t5_wr3", 1, 8'($urandom), 0, 0);
        cycle("t5_both_mid", 1, 8'h5A, 1, 0);
        chk("t5_count3", 32'(f_count), 32'd3);
        for (int i = 0; i < 3; i++) cycle("t5_drain", 0, 8'h00, 1, 0);
        cycle("t5_both_empty", 1, 8'h3C, 1, 0);
        chk("t5_count1", 32'(f_count), 32'd1);
        chk("t5_udf", 32'(f_udf), 32'd1);
        for (int i = 0; i < 7; i++) cycle("t5_fill", 1, 8'($urandom), 0, 0);
        cycle("t5_both_full", 1, 8'hC3, 1, 0);
        chk("t5_count7", 32'(f_count), 32'd7);
        chk("t5_ovf", 32'(f_ovf), 32'd1);
        cycle("t5_clr", 0, 8'h00, 0, 1);
        chk("t5_clr_ovf", 32'(r_ovf), 32'd0);
        chk("t5_clr_udf", 32'(r_udf), 32'd0);

        // 6: registered-read latency
        for (int i = 0; i < 7; i++) cycle("t6_flush", 0, 8'h00, 1, 0);
        cycle("t6_wr", 1, 8'h6D, 0, 0);
        cycle("t6_rd", 0, 8'h00, 1, 0);
        chk("t6_valid_n1", 32'(r_rd_valid), 32'd1);
        chk("t6_data_n1", 32'(r_rd_data), 32'h6D);
        cycle("t6_idle", 0, 8'h00, 0, 0);
        chk("t6_valid_n2", 32'(r_rd_valid), 32'd0);
        chk("t6_data_hold", 32'(r_rd_data), 32'h6D);

        // Random traffic with drifting write/read bias
        for (int i = 0; i < 600; i++) begin
            int wbias;
            wbias = ((i / 100) % 2 == 0) ? 70 : 30;
            cycle("rand",
                  ($urandom_range(0, 99) < wbias),
                  8'($urandom),
                  ($urandom_range(0, 99) < (100 - wbias)),
                  ($urandom_range(0, 99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
